mem_access_stage: RTL and testbench

- MEM-stage data-memory unit, directly downstream of the EX/MEM pipeline register.
- Takes address, store data and memory controls from EX/MEM; performs word/half/byte load or store on an internal byte-enabled data RAM with configurable wait states.
- Drives a stall to freeze IF/ID/EX/EX-MEM register enables while an access is in flight.
- Presents the aligned, extended load result to the MEM/WB register.

---
 rtl/mem_pkg.sv | 59 +++++
 rtl/dmem_bram.sv | 44 ++++
 rtl/mem_access_stage.sv | 194 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : mem_pkg                                                     |
// | Description : Shared definitions for the MEM-stage data-memory unit:      |
// |               access-size encodings, FSM state encodings, byte-lane       |
// |               enable constants, the latched request record and lane       |
// |               helper functions.                                           |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
package mem_pkg;

   // Access size encodings (2'b11 is handled as a word access)
   localparam logic [1:0] MODE_WORD = 2'b00;
   localparam logic [1:0] MODE_BYTE = 2'b01;
   localparam logic [1:0] MODE_HALF = 2'b10;

   // Access FSM state encodings
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Byte-lane enables, lane 0 = least significant byte (little-endian)
   localparam logic [3:0] BE_NONE = 4'b0000;
   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   // Request captured in IDLE and held for the whole access
   typedef struct packed {
      logic        store;
      logic [1:0]  mode;
      logic        sext;
      logic        misalign;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_req_t;

   // Lanes touched by an access; misaligned low bits are simply ignored,
   // which forces half and word accesses onto their natural boundary.
   function automatic logic [3:0] lane_enables(input logic [1:0] mode,
                                               input logic [1:0] a);
      case (mode)
         MODE_BYTE: return BE_BYTE << a;
         MODE_HALF: return BE_HALF << {a[1], 1'b0};
         default:   return BE_WORD;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [1:0] mode,
                                          input logic [1:0] a);
      case (mode)
         MODE_BYTE: return 1'b0;
         MODE_HALF: return a[0];
         default:   return (a != 2'b00);
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_bram.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : dmem_bram                                                   |
// | Description : Single-port synchronous data RAM, 32-bit words with a       |
// |               4-bit byte-write enable and a registered read port.         |
// |   clk     in   clock                                                      |
// |   i_en    in   access enable (read and/or write this edge)                |
// |   i_we    in   byte-write enables, bit n writes bits [8n+7:8n]            |
// |   i_addr  in   word address                                               |
// |   i_wdata in   write data                                                 |
// |   o_rdata out  read data, one cycle after the address is presented        |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module dmem_bram #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  i_en,
   input  logic [3:0]            i_we,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [31:0]           i_wdata,
   output logic [31:0]           o_rdata
);

   logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];
   logic [31:0] rdata_q;

   // Contents are deliberately never reset; a read concurrent with a write
   // returns the old word.
   always_ff @(posedge clk) begin
      if (i_en) begin
         for (int i = 0; i < 4; i++) begin
            if (i_we[i]) begin
               mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
            end
         end
         rdata_q <= mem[i_addr];
      end
   end

   assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : mem_access_stage                                            |
// | Description : MEM-stage data-memory unit. Accepts a load/store from the   |
// |               EX/MEM register, runs it against the data RAM with LATENCY  |
// |               wait cycles while stalling upstream, and presents the       |
// |               aligned, extended load result to MEM/WB.                    |
// |   clk            in   clock                                              |
// |   clr            in   synchronous active-high reset                      |
// |   Enable_in      in   instruction valid                                  |
// |   Memwrite_in    in   store request (wins over Memtoreg_in)              |
// |   Memtoreg_in    in   load request                                       |
// |   Mode_in        in   00 word, 01 byte, 10 half, 11 word                 |
// |   Signext2_in    in   1 sign-extend loads, 0 zero-extend                 |
// |   ALU_Result1_in in   byte address                                       |
// |   RD2_in         in   store data                                         |
// |   Load_Data_out  out  extended load result, held until next load         |
// |   Stall_out      out  hold upstream stages                               |
// |   Done_out       out  one-cycle completion pulse                         |
// |   Misalign_out   out  (MEM_MISALIGN_TRAP_EN only) misaligned access      |
// | Optional    : define MEM_MISALIGN_TRAP_EN to trap misaligned accesses    |
// |               instead of silently aligning them.                         |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        Enable_in,
   input  logic        Memwrite_in,
   input  logic        Memtoreg_in,
   input  logic [1:0]  Mode_in,
   input  logic        Signext2_in,
   input  logic [31:0] ALU_Result1_in,
   input  logic [31:0] RD2_in,
   output logic [31:0] Load_Data_out,
   output logic        Stall_out,
   output logic        Done_out
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic        Misalign_out
`endif
);

   localparam logic [3:0] c_LAST_CNT = 4'(LATENCY);

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   mem_req_t    req_q, req_d;
   logic [31:0] load_data_q, load_data_d;

   logic                  w_req;
   logic                  w_last;
   logic                  w_commit_ok;
   logic                  w_ram_en;
   logic [3:0]            w_ram_we;
   logic [ADDR_WIDTH-1:0] w_ram_addr;
   logic [31:0]           w_ram_wdata;
   logic [31:0]           w_ram_rdata;
   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic [31:0]           w_load_ext;

   assign w_req  = Enable_in & (Memwrite_in | Memtoreg_in);
   assign w_last = (state_q == ST_WAIT) && (cnt_q == c_LAST_CNT);

`ifdef MEM_MISALIGN_TRAP_EN
   assign w_commit_ok = ~req_q.misalign;
`else
   assign w_commit_ok = 1'b1;
`endif

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         req_q       <= '0;
         load_data_q <= 32'h0000_0000;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         load_data_q <= load_data_d;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      case (state_q)
         ST_IDLE: begin
            if (w_req) begin
               req_d.store    = Memwrite_in;
               req_d.mode     = Mode_in;
               req_d.sext     = Signext2_in;
               req_d.misalign = is_misaligned(Mode_in, ALU_Result1_in[1:0]);
               req_d.addr     = ALU_Result1_in;
               req_d.wdata    = RD2_in;
               cnt_d          = 4'd1;
               state_d        = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == c_LAST_CNT) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // --------------------------------------------------------------- outputs
   always_comb begin
      Stall_out = ((state_q == ST_IDLE) && w_req) || (state_q == ST_WAIT);
      Done_out  = (state_q == ST_DONE);
`ifdef MEM_MISALIGN_TRAP_EN
      Misalign_out = (state_q == ST_DONE) && req_q.misalign;
`endif
   end

   // ------------------------------------------------------------ RAM access
   // In IDLE the RAM address follows the live input so that a one-cycle wait
   // still has valid read data by the final WAIT cycle.
   assign w_ram_en   = 1'b1;
   assign w_ram_addr = (state_q == ST_IDLE) ? ALU_Result1_in[ADDR_WIDTH+1:2]
                                            : req_q.addr[ADDR_WIDTH+1:2];

   always_comb begin
      w_ram_wdata = req_q.wdata;
      case (req_q.mode)
         MODE_BYTE: w_ram_wdata = {4{req_q.wdata[7:0]}};
         MODE_HALF: w_ram_wdata = {2{req_q.wdata[15:0]}};
         default:   w_ram_wdata = req_q.wdata;
      endcase
      // clr on the commit edge aborts the access, so it must gate the write
      if (w_last && req_q.store && w_commit_ok && !clr) begin
         w_ram_we = lane_enables(req_q.mode, req_q.addr[1:0]);
      end else begin
         w_ram_we = BE_NONE;
      end
   end

   dmem_bram #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_dmem_bram (
      .clk     (clk),
      .i_en    (w_ram_en),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_addr),
      .i_wdata (w_ram_wdata),
      .o_rdata (w_ram_rdata)
   );

   // ---------------------------------------------------- load lane + extend
   always_comb begin
      w_byte     = w_ram_rdata[{req_q.addr[1:0], 3'b000} +: 8];
      w_half     = req_q.addr[1] ? w_ram_rdata[31:16] : w_ram_rdata[15:0];
      w_load_ext = w_ram_rdata;
      case (req_q.mode)
         MODE_BYTE: w_load_ext = req_q.sext ? {{24{w_byte[7]}}, w_byte}
                                            : {24'h00_0000, w_byte};
         MODE_HALF: w_load_ext = req_q.sext ? {{16{w_half[15]}}, w_half}
                                            : {16'h0000, w_half};
         default:   w_load_ext = w_ram_rdata;
      endcase
      load_data_d = load_data_q;
      if (w_last && !req_q.store && w_commit_ok) begin
         load_data_d = w_load_ext;
      end
   end

   assign Load_Data_out = load_data_q;

   // Address bits above the RAM index wrap silently
   logic w_unused_ok;
`ifdef MEM_MISALIGN_TRAP_EN
   assign w_unused_ok = ^{ALU_Result1_in[31:ADDR_WIDTH+2], req_q.addr[31:ADDR_WIDTH+2]};
`else
   assign w_unused_ok = ^{ALU_Result1_in[31:ADDR_WIDTH+2], req_q.addr[31:ADDR_WIDTH+2],
                          req_q.misalign};
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : tb_mem_access_stage                                         |
// | Description : Directed self-checking bench for mem_access_stage with      |
// |               LATENCY = 2 (3 stall cycles, 1 done cycle per access).      |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module tb_mem_access_stage;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        clr;
   logic        Enable_in;
   logic        Memwrite_in;
   logic        Memtoreg_in;
   logic [1:0]  Mode_in;
   logic        Signext2_in;
   logic [31:0] ALU_Result1_in;
   logic [31:0] RD2_in;
   logic [31:0] Load_Data_out;
   logic        Stall_out;
   logic        Done_out;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        Misalign_out;
`endif

   int total = 0;
   int bad   = 0;
   int st_cyc;
   int dn_cyc;
   int mis_cyc;

   always #5 clk = ~clk;

   mem_access_stage #(
      .ADDR_WIDTH (10),
      .LATENCY    (LAT)
   ) dut (
      .clk            (clk),
      .clr            (clr),
      .Enable_in      (Enable_in),
      .Memwrite_in    (Memwrite_in),
      .Memtoreg_in    (Memtoreg_in),
      .Mode_in        (Mode_in),
      .Signext2_in    (Signext2_in),
      .ALU_Result1_in (ALU_Result1_in),
      .RD2_in         (RD2_in),
      .Load_Data_out  (Load_Data_out),
      .Stall_out      (Stall_out),
      .Done_out       (Done_out)
`ifdef MEM_MISALIGN_TRAP_EN
      ,
      .Misalign_out   (Misalign_out)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One access: drive at a negedge, sample each following negedge+1 until
   // Done_out is seen (bounded), then release the inputs after DONE's edge.
   task automatic access(input string tag, input logic st, input logic [1:0] md,
                         input logic sx, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      Enable_in      = 1'b1;
      Memwrite_in    = st;
      Memtoreg_in    = ~st;
      Mode_in        = md;
      Signext2_in    = sx;
      ALU_Result1_in = a;
      RD2_in         = d;
      st_cyc  = 0;
      dn_cyc  = 0;
      mis_cyc = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (Stall_out) st_cyc++;
         if (Done_out)  dn_cyc++;
`ifdef MEM_MISALIGN_TRAP_EN
         if (Misalign_out) mis_cyc++;
`endif
         @(negedge clk);
         if (dn_cyc != 0) break;
      end
      Enable_in   = 1'b0;
      Memwrite_in = 1'b0;
      Memtoreg_in = 1'b0;
      chk({tag, ".done"}, 32'(dn_cyc), 32'd1);
      chk({tag, ".stall"}, 32'(st_cyc), 32'(LAT + 1));
   endtask

   initial begin
      clr = 1'b1; Enable_in = 1'b0; Memwrite_in = 1'b0; Memtoreg_in = 1'b0;
      Mode_in = 2'b00; Signext2_in = 1'b0; ALU_Result1_in = 32'h0; RD2_in = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst.load",  Load_Data_out, 32'h0);
      chk("rst.done",  32'(Done_out), 32'd0);
      chk("rst.stall", 32'(Stall_out), 32'd0);
      @(negedge clk);
      clr = 1'b0;

      // word store / load, address wrap
      access("sw10", 1'b1, 2'b00, 1'b0, 32'h10, 32'h1234_5678);
      chk("sw10.load_kept", Load_Data_out, 32'h0);
      access("lw10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
      chk("lw10.val", Load_Data_out, 32'h1234_5678);
      access("lw1010", 1'b0, 2'b00, 1'b0, 32'h1010, 32'h0);
      chk("lw1010.wrap", Load_Data_out, 32'h1234_5678);

      // byte store into a cleared word, byte loads
      access("sw10z", 1'b1, 2'b00, 1'b0, 32'h10, 32'h0);
      access("sb11", 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_00AB);
      chk("sb11.load_kept", Load_Data_out, 32'h1234_5678);
      access("lw10b", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
      chk("lw10b.val", Load_Data_out, 32'h0000_AB00);
      access("lb11s", 1'b0, 2'b01, 1'b1, 32'h11, 32'h0);
      chk("lb11s.val", Load_Data_out, 32'hFFFF_FFAB);
      access("lb11z", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
      chk("lb11z.val", Load_Data_out, 32'h0000_00AB);

      // half store into upper lane pair, half and word loads
      access("sw20z", 1'b1, 2'b00, 1'b0, 32'h20, 32'h0);
      access("sh22", 1'b1, 2'b10, 1'b0, 32'h22, 32'h0000_8001);
      access("lh22s", 1'b0, 2'b10, 1'b1, 32'h22, 32'h0);
      chk("lh22s.val", Load_Data_out, 32'hFFFF_8001);
      access("lh22z", 1'b0, 2'b10, 1'b0, 32'h22, 32'h0);
      chk("lh22z.val", Load_Data_out, 32'h0000_8001);
      access("lw20", 1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
      chk("lw20.val", Load_Data_out, 32'h8001_0000);

      // non-memory instructions pass without stalling
      @(negedge clk);
      Enable_in = 1'b1; Memwrite_in = 1'b0; Memtoreg_in = 1'b0;
      st_cyc = 0; dn_cyc = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (Stall_out) st_cyc++;
         if (Done_out)  dn_cyc++;
         @(negedge clk);
      end
      Enable_in = 1'b0; Memwrite_in = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         if (Stall_out) st_cyc++;
         if (Done_out)  dn_cyc++;
         @(negedge clk);
      end
      Memwrite_in = 1'b0;
      chk("nomem.stall", 32'(st_cyc), 32'd0);
      chk("nomem.done",  32'(dn_cyc), 32'd0);
      chk("nomem.load",  Load_Data_out, 32'h8001_0000);

      // clr in the first WAIT cycle aborts a store
      access("sw30z", 1'b1, 2'b00, 1'b0, 32'h30, 32'h0);
      @(negedge clk);
      Enable_in = 1'b1; Memwrite_in = 1'b1; Memtoreg_in = 1'b0; Mode_in = 2'b00;
      ALU_Result1_in = 32'h30; RD2_in = 32'hDEAD_BEEF;
      #1;
      chk("abort.stall_req", 32'(Stall_out), 32'd1);
      @(negedge clk);
      clr = 1'b1;
      #1;
      chk("abort.stall_wait", 32'(Stall_out), 32'd1);
      @(negedge clk);
      clr = 1'b0; Enable_in = 1'b0; Memwrite_in = 1'b0;
      dn_cyc = 0; st_cyc = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (Stall_out) st_cyc++;
         if (Done_out)  dn_cyc++;
         @(negedge clk);
      end
      chk("abort.no_done",  32'(dn_cyc), 32'd0);
      chk("abort.no_stall", 32'(st_cyc), 32'd0);
      chk("abort.load_clr", Load_Data_out, 32'h0);
      access("lw30", 1'b0, 2'b00, 1'b0, 32'h30, 32'h0);
      chk("lw30.val", Load_Data_out, 32'h0);

      // misaligned accesses
      access("sw04z", 1'b1, 2'b00, 1'b0, 32'h04, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
      access("lw10c", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
      chk("lw10c.val", Load_Data_out, 32'h0000_AB00);
      access("lw13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
      chk("lw13.mis",  32'(mis_cyc), 32'd1);
      chk("lw13.kept", Load_Data_out, 32'h0000_AB00);
      access("sh05", 1'b1, 2'b10, 1'b0, 32'h05, 32'h0000_1234);
      chk("sh05.mis", 32'(mis_cyc), 32'd1);
      access("lw04", 1'b0, 2'b00, 1'b0, 32'h04, 32'h0);
      chk("lw04.mis", 32'(mis_cyc), 32'd0);
      chk("lw04.val", Load_Data_out, 32'h0);
`else
      access("lh23", 1'b0, 2'b10, 1'b1, 32'h23, 32'h0);
      chk("lh23.align", Load_Data_out, 32'hFFFF_8001);
      access("lw13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
      chk("lw13.align", Load_Data_out, 32'h0000_AB00);
      access("sh05", 1'b1, 2'b10, 1'b0, 32'h05, 32'h0000_1234);
      access("lw04", 1'b0, 2'b00, 1'b0, 32'h04, 32'h0);
      chk("lw04.val", Load_Data_out, 32'h0000_1234);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
